// File: rtl/spi_xfer_engine.sv
`default_nettype none
// ============================================================================
// Module   : spi_xfer_engine
// Purpose  : SPI mode-0 master. Runs one transaction per accepted request:
//            opcode byte, optional address bytes, optional dummy bits and a
//            0..DATA_BYTES byte data phase. Generates per-device chip selects
//            and a programmable SCLK (half-period = clk_div+1 clk cycles).
// Ports    : clk/rst            - clock, synchronous active-high reset
//            req_*              - valid/ready request, latched at accept
//            clk_div            - SCLK half-period minus one, latched at accept
//            rsp_valid/rsp_rdata- one-cycle completion pulse, read data
//            busy               - transaction in progress (SETUP..DONE)
//            sclk/mosi/cs_n/miso- SPI pins (outputs registered)
// Options  : SPI_XFER_DUMMY_EN  - adds req_dummy[4:0] dummy-bit count port
// Revision : 1.0 - initial release
// ============================================================================
module spi_xfer_engine #(
  parameter int ADDR_BITS  = 24,
  parameter int DATA_BYTES = 4,
  parameter int NUM_CS     = 2,
  parameter int DIV_BITS   = 4,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int LEN_W = $clog2(DATA_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [CS_W-1:0]         req_cs,
  input  logic [7:0]              req_cmd,
  input  logic                    req_addr_en,
  input  logic [ADDR_BITS-1:0]    req_addr,
  input  logic                    req_write,
  input  logic [LEN_W-1:0]        req_len,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
`ifdef SPI_XFER_DUMMY_EN
  input  logic [4:0]              req_dummy,
`endif
  input  logic [DIV_BITS-1:0]     clk_div,
  output logic                    rsp_valid,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    busy,
  output logic                    sclk,
  output logic                    mosi,
  output logic [NUM_CS-1:0]       cs_n,
  input  logic                    miso
);

  localparam int DW       = 8 * DATA_BYTES;
  localparam int MAX_BITS = 8 + ADDR_BITS + 31 + DW;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam int WIDX_W   = $clog2(DW);
  localparam int AIDX_W   = $clog2(ADDR_BITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Request fields captured at accept
  logic [7:0]           r_cmd;
  logic                 r_addr_en;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_write;
  logic [LEN_W-1:0]     r_len;
  logic [DW-1:0]        r_wdata;
  logic [CS_W-1:0]      r_cs;
  logic [4:0]           r_dummy;
  logic [DIV_BITS-1:0]  r_div;

  logic [DIV_BITS-1:0]  r_div_cnt;
  logic [CNT_W-1:0]     r_bit_idx;
  logic [DW-1:0]        r_rdata;
  logic                 r_sclk;
  logic                 r_mosi;
  logic [NUM_CS-1:0]    r_cs_n;
  logic                 r_rsp_valid;
  logic                 r_busy;

  logic                 w_ready;
  logic                 w_accept;
  logic [4:0]           w_req_dummy;
  logic [LEN_W-1:0]     w_req_len_clamped;
  logic                 w_phase_end;
  logic [CNT_W-1:0]     w_addr_end;
  logic [CNT_W-1:0]     w_data_start;
  logic [CNT_W-1:0]     w_total;
  logic                 w_last;
  logic [CNT_W-1:0]     w_nxt_idx;
  logic [AIDX_W-1:0]    w_aidx_nxt;
  logic [WIDX_W-1:0]    w_widx_nxt;
  logic [WIDX_W-1:0]    w_widx_cur;
  logic                 w_nxt_bit;
  logic                 w_rx_bit;
  logic                 w_sel_active;
  logic [CS_W-1:0]      w_sel_cs;
  logic                 w_mosi_nxt;
  logic [NUM_CS-1:0]    w_cs_n_nxt;

`ifdef SPI_XFER_DUMMY_EN
  assign w_req_dummy = req_dummy;
`else
  assign w_req_dummy = 5'd0;
`endif

  assign w_ready  = (r_state == S_IDLE) && !rst;
  assign w_accept = req_valid && w_ready;

  assign w_req_len_clamped = (int'(req_len) > DATA_BYTES) ? LEN_W'(DATA_BYTES) : req_len;

  // Bit-index layout of the transaction: [cmd | addr | dummy | data]
  assign w_addr_end   = r_addr_en ? CNT_W'(8 + ADDR_BITS) : CNT_W'(8);
  assign w_data_start = w_addr_end + CNT_W'(r_dummy);
  assign w_total      = w_data_start + CNT_W'({r_len, 3'b000});
  assign w_last       = (r_bit_idx == w_total - CNT_W'(1));
  assign w_phase_end  = (r_div_cnt == r_div);

  // Bit positions: address sent MSB first; within each data byte, MSB first
  // (low three offset bits inverted), byte 0 first.
  assign w_nxt_idx  = r_bit_idx + CNT_W'(1);
  assign w_aidx_nxt = AIDX_W'(CNT_W'(ADDR_BITS + 7) - w_nxt_idx);
  assign w_widx_nxt = WIDX_W'(w_nxt_idx - w_data_start) ^ WIDX_W'(7);
  assign w_widx_cur = WIDX_W'(r_bit_idx - w_data_start) ^ WIDX_W'(7);

  always_comb begin
    w_nxt_bit = 1'b0;
    if (w_nxt_idx < CNT_W'(8))
      w_nxt_bit = r_cmd[~w_nxt_idx[2:0]];
    else if (w_nxt_idx < w_addr_end)
      w_nxt_bit = r_addr[w_aidx_nxt];
    else if (w_nxt_idx >= w_data_start && r_write)
      w_nxt_bit = r_wdata[w_widx_nxt];
  end

  // Only read-data bits are captured; dummy and preamble bits are ignored
  assign w_rx_bit = !r_write && (r_bit_idx >= w_data_start);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid)   w_state_nxt = S_SETUP;
      S_SETUP: if (w_phase_end) w_state_nxt = S_HIGH;
      S_HIGH:  if (w_phase_end) w_state_nxt = w_last ? S_HOLD : S_LOW;
      S_LOW:   if (w_phase_end) w_state_nxt = S_HIGH;
      S_HOLD:  if (w_phase_end) w_state_nxt = S_DONE;
      S_DONE:                   w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // Pin values are derived from the next state so that the registered
  // outputs change on the same edge as the state register.
  always_comb begin
    w_sel_active = (w_state_nxt == S_SETUP) || (w_state_nxt == S_HIGH) ||
                   (w_state_nxt == S_LOW)   || (w_state_nxt == S_HOLD);
    w_sel_cs     = (r_state == S_IDLE) ? req_cs : r_cs;
    w_mosi_nxt   = 1'b0;
    if (r_state == S_IDLE && w_state_nxt == S_SETUP)
      w_mosi_nxt = req_cmd[7];
    else if (r_state == S_HIGH && w_state_nxt == S_LOW)
      w_mosi_nxt = w_nxt_bit;
    else if (w_state_nxt == S_SETUP || w_state_nxt == S_HIGH || w_state_nxt == S_LOW)
      w_mosi_nxt = r_mosi;
  end

  // An out-of-range select index matches no output, so no device is selected
  for (genvar i = 0; i < NUM_CS; i++) begin : g_cs
    assign w_cs_n_nxt[i] = !(w_sel_active && (w_sel_cs == CS_W'(i)));
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cmd     <= req_cmd;
      r_addr_en <= req_addr_en;
      r_addr    <= req_addr;
      r_write   <= req_write;
      r_len     <= w_req_len_clamped;
      r_wdata   <= req_wdata;
      r_cs      <= req_cs;
      r_dummy   <= w_req_dummy;
      r_div     <= clk_div;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div_cnt   <= '0;
      r_bit_idx   <= '0;
      r_rdata     <= '0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_cs_n      <= '1;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sclk      <= (w_state_nxt == S_HIGH);
      r_mosi      <= w_mosi_nxt;
      r_cs_n      <= w_cs_n_nxt;
      r_rsp_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
      if (r_state == S_IDLE) begin
        r_div_cnt <= '0;
        if (req_valid) begin
          r_bit_idx <= '0;
          r_rdata   <= '0;
        end
      end else begin
        if (w_phase_end || r_state == S_DONE)
          r_div_cnt <= '0;
        else
          r_div_cnt <= r_div_cnt + DIV_BITS'(1);
        // The edge ending a HIGH phase samples miso and advances the bit
        if (r_state == S_HIGH && w_phase_end) begin
          if (w_rx_bit)
            r_rdata[w_widx_cur] <= miso;
          if (!w_last)
            r_bit_idx <= w_nxt_idx;
        end
      end
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign busy      = r_busy;
  assign sclk      = r_sclk;
  assign mosi      = r_mosi;
  assign cs_n      = r_cs_n;

endmodule
`default_nettype wire

// File: doc/spi_xfer_engine.md
# spi_xfer_engine

Parametrised successor SPI master for the MCU's memory/peripheral bus. Runs one SPI mode-0 transaction per request: an opcode byte, an optional address, optional dummy bits, and a variable-length data phase of 0..DATA_BYTES bytes. Adds chip-select generation for several devices, a programmable SCLK divider, synchronous reset and a valid/ready request handshake. Sits between the CPU load/store unit and external flash, RAM and SPI peripherals.

## Interface
- ADDR_BITS, 24, address width; must be a multiple of 8 (8..32)
- DATA_BYTES, 4, maximum data-phase bytes (1..8)
- NUM_CS, 2, number of chip-select outputs
- DIV_BITS, 4, width of clk_div

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE and not in reset
- req_cs  in  max(1,clog2(NUM_CS))  target device index
- req_cmd  in  8  opcode, sent MSB first
- req_addr_en  in  1  send ADDR_BITS/8 address bytes after the opcode
- req_addr  in  ADDR_BITS  address, MSB first
- req_write  in  1  1: data phase drives req_wdata; 0: mosi=0, miso captured
- req_len  in  clog2(DATA_BYTES+1)  data bytes; 0 = command/address only
- req_wdata  in  8*DATA_BYTES  byte k = bits [8k+7:8k]; byte 0 sent first, each byte MSB first
- clk_div  in  DIV_BITS  SCLK half-period = clk_div+1 clk cycles
- rsp_valid  out  1  one-cycle pulse at transaction end
- rsp_rdata  out  8*DATA_BYTES  received byte k in [8k+7:8k]; unreceived bytes 0
- busy  out  1  high from SETUP through DONE
- sclk, mosi  out  1  SPI, registered
- cs_n  out  NUM_CS  active-low selects, registered
- miso  in  1  SPI data in

## Operation
- States: IDLE, SETUP, HIGH, LOW, HOLD, DONE.
- Request accepted on a clock edge with req_valid && req_ready. All req_* inputs and clk_div are latched at that edge; later changes have no effect.
- Bit count N = 8 + 8*req_addr_en*ADDR_BITS/8 + dummy + 8*len. len = min(req_len, DATA_BYTES).
- SETUP: cs_n[req_cs]=0, sclk=0, mosi=first bit. HIGH: sclk=1. LOW: sclk=0, mosi advances to the next bit. Each phase lasts clk_div+1 cycles.
- Transitions: SETUP→HIGH. HIGH→LOW while bits remain, otherwise HIGH→HOLD. LOW→HIGH. HOLD (sclk=0, cs still low)→DONE. DONE (cs_n all 1, rsp_valid=1)→IDLE.
- miso is sampled on the clk edge that ends each HIGH phase. Only data-phase bits with req_write=0 are stored, shifted into byte k MSB first.
- rsp_rdata is cleared at accept and holds its value after DONE until the next accept. For writes it returns 0.
- req_cs ≥ NUM_CS: no cs_n asserted, transaction otherwise runs normally.
- mosi = 0 during dummy bits, during read data bits, and outside SETUP/HIGH/LOW.

## Timing
- Accept at edge t; SETUP starts at cycle t+1. rsp_valid is high in cycle t+1+(2N+1)(clk_div+1).
- Back-to-back: req_ready returns in the cycle after DONE, so cs_n stays high for at least 2 cycles between transactions.
- Reset values (cycle after rst sampled high): state IDLE, cs_n all 1, sclk 0, mosi 0, rsp_valid 0, rsp_rdata 0, busy 0. req_ready is 0 while rst=1 and 1 afterwards.
- Reset mid-transaction aborts it: cs_n deasserts next cycle and no rsp_valid is issued.
- rst has priority over a simultaneous request.

## Configuration
- SPI_XFER_DUMMY_EN defined:
  - Adds input req_dummy [4:0], the dummy bit count (0..31), latched at accept.
  - Dummy bits are inserted between the address and data phases and counted in N.
  - miso is ignored during dummy bits.
  - Required for fast read (0x0B).
- SPI_XFER_DUMMY_EN undefined: the port is absent and dummy = 0.

## Test plan
- Reset: rst high 2 cycles, then low → cs_n=2'b11, sclk=0, mosi=0, rsp_valid=0, req_ready=1.
- Command-only 0x06, req_cs=1, clk_div=0 → cs_n=2'b01; mosi at rising sclk edges is 0,0,0,0,0,1,1,0; rsp_valid in cycle t+18; rsp_rdata=0.
- Read 0x03, addr 0x001234, len 4, clk_div=0, miso model returns AA,BB,CC,DD → mosi 03 00 12 34; rsp_rdata=0xDDCCBBAA at cycle t+130.
- Write 0x02, addr 0x000010, len 2, wdata 0x0000BEEF, clk_div=3 → mosi 02 00 00 10 EF BE; every sclk phase is 4 cycles; rsp_valid at t+1+97*4; req_valid held high during busy is not accepted.
- rst asserted 20 cycles after accept → cs_n all 1 next cycle, no rsp_valid; a following read completes correctly.
- (SPI_XFER_DUMMY_EN) 0x0B, addr 0x000000, dummy 8, len 1, miso 0x5A after dummy → rsp_rdata[7:0]=0x5A; N=48.
